reg_hex_formatter: RTL and testbench
====================================

# reg_hex_formatter

Converts the 32 architectural register values into ASCII hex text for the VGA register display. Sits directly downstream of the register file's debug outputs and upstream of the VGA text buffer. On each START it walks registers 0..31 through a 5-bit read select and emits one line per register, `xNN: HHHHHHHH`, into the text buffer's write port with ready/valid backpressure.

## Interface
- COLS, 80, text buffer columns per row
- BASE_ROW, 0, row of register 0's line
- BASE_COL, 0, column of each line's first character
- ADDR_W, 12, text buffer address width
- CLK  in  1  clock; all state updates on the rising edge
- RST_RF  in  1  reset, asynchronous, active-high; clock CLK
- START  in  1  one-cycle refresh request; sampled only in IDLE
- RA  out  5  register select; the top level muxes R0..R31 onto RDATA
- RDATA  in  32  selected register value; combinational from RA
- WR_EN  out  1  character write valid
- WR_ADDR  out  ADDR_W  text buffer cell address
- WR_DATA  out  8  ASCII character
- WR_READY  in  1  text buffer accepts the write
- BUSY  out  1  refresh in progress
- DONE  out  1  one-cycle pulse after the last character is accepted

## Operation
- States: IDLE, FETCH, EMIT, FINISH.
- IDLE: BUSY=0, WR_EN=0. START=1 clears the register index idx to 0 and moves to FETCH.
- FETCH: RA=idx. The rising edge latches RDATA into a 32-bit snapshot, clears the char index c to 0, and moves to EMIT.
- EMIT: WR_EN=1. WR_DATA is character c of the line, and WR_ADDR=(BASE_ROW+idx)*COLS+BASE_COL+c, truncated modulo 2^ADDR_W.
  - A transfer occurs on an edge with WR_EN&&WR_READY. Only a transfer advances c.
  - When c=12 transfers: if idx=31, go to FINISH; else idx+1 and go to FETCH.
- Line layout, c=0..12: 'x'(0x78); tens digit '0'..'3'; ones digit '0'..'9'; ':'(0x3A); ' '(0x20); snapshot nibbles [31:28] down to [3:0].
- Hex digits: 0-9 map to 0x30-0x39; 10-15 map to uppercase 0x41-0x46.
- FINISH: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- RA holds idx in EMIT and FINISH, and holds the last value in IDLE. The snapshot makes RDATA changes after FETCH invisible to the current line.
- START outside IDLE is ignored and not queued. START in the FINISH cycle is ignored. START in IDLE starts a new pass.
- While WR_READY=0, WR_EN, WR_ADDR and WR_DATA hold stable.
- RST_RF, asynchronous, including mid-refresh:
  - state goes to IDLE; idx, c and the snapshot clear to 0.
  - RA=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, DONE=0.
  - No partial line is completed after reset release.

## Timing
- Reset values of all outputs: 0.
- START sampled high at edge T: BUSY=1 and FETCH for register 0 in cycle T+1.
- With WR_READY held high:
  - register 0's characters are presented in cycles T+2..T+14.
  - each register takes 14 cycles: 1 FETCH + 13 EMIT.
  - the last character is accepted at the end of cycle T+448.
  - DONE pulses in cycle T+449, with BUSY=0 in that same cycle.
- Each stalled cycle (WR_READY=0 in EMIT) adds exactly one cycle and changes nothing else.
- BUSY is registered: 1 from cycle T+1 up to the FINISH cycle.

## Test plan
- Reset and idle: RST_RF pulse with no START -> every output 0; WR_EN stays 0 for 100 cycles.
- Full pass with RDATA=idx, WR_READY=1, defaults -> 416 writes.
  - Row 10 is addresses 800..812 carrying "x10: 0000000A".
  - Row 31 ends with 'F' at address 2492.
  - DONE is a single pulse at T+449.
- Hex and digit mapping: RDATA=0xDEADBEEF for idx 7 -> "x07: DEADBEEF" at 560..572. RDATA=0x01234567 -> "01234567".
- Backpressure: WR_READY toggles 1,0,0,1 repeating -> outputs stable through every stall, each character written once in order, DONE delayed by exactly the stall count.
- Snapshot and START: change RDATA during idx 3's EMIT -> line 3 shows the FETCH-time value. START pulses mid-pass -> no restart and a single DONE.
- Reset mid-operation: RST_RF during idx 5, c=6 -> outputs 0 immediately. After release, WR_EN stays 0 until the next START, and the new pass begins at row 0.

Source files
------------

// File: rtl/reg_hex_formatter_if.sv
// Text buffer character write port with ready/valid backpressure.
interface reg_hex_formatter_if #(
  parameter int ADDR_W = 12
);
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic              WR_READY;

  modport master (output WR_EN, WR_ADDR, WR_DATA, input WR_READY);
  modport slave  (input WR_EN, WR_ADDR, WR_DATA, output WR_READY);
endinterface

// File: rtl/reg_hex_formatter.sv
// Walks registers 0..31 and writes one "xNN: HHHHHHHH" line per register
// into the VGA text buffer through a ready/valid character write port.
module reg_hex_formatter #(
  parameter int COLS     = 80,
  parameter int BASE_ROW = 0,
  parameter int BASE_COL = 0,
  parameter int ADDR_W   = 12
) (
  input  logic                CLK,
  input  logic                RST_RF,
  input  logic                START,
  output logic [4:0]          RA,
  input  logic [31:0]         RDATA,
  reg_hex_formatter_if.master wr,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [3:0]  c, c_nx;
  logic [31:0] snap, snap_nx;
  logic        busy_q;

  logic [4:0]  tens, ones;
  logic [4:0]  sh;
  logic [3:0]  nib;
  logic [7:0]  ch;
  logic [31:0] addr_full;

  // State and datapath registers; reset abandons any partial line.
  always_ff @(posedge CLK or posedge RST_RF) begin
    if (RST_RF) begin
      state  <= IDLE;
      idx    <= '0;
      c      <= '0;
      snap   <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      c      <= c_nx;
      snap   <= snap_nx;
      busy_q <= (state_nx == FETCH) || (state_nx == EMIT);
    end
  end

  // Next-state: only an accepted character (EMIT with READY) advances c.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    c_nx     = c;
    snap_nx  = snap;
    case (state)
      IDLE: begin
        if (START) begin
          idx_nx   = '0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        snap_nx  = RDATA;
        c_nx     = '0;
        state_nx = EMIT;
      end
      EMIT: begin
        if (wr.WR_READY) begin
          if (c == 4'd12) begin
            if (idx == 5'd31) state_nx = FINISH;
            else begin
              idx_nx   = idx + 5'd1;
              state_nx = FETCH;
            end
          end else begin
            c_nx = c + 4'd1;
          end
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Character generator: label, decimal index, separator, then hex nibbles MSB first.
  always_comb begin
    tens = idx / 5'd10;
    ones = idx % 5'd10;
    // nibble position counts down from 7 (bits 31:28) at c=5 to 0 at c=12
    sh   = {3'(4'd12 - c), 2'b00};
    nib  = 4'(snap >> sh);
    case (c)
      4'd0:    ch = 8'h78;
      4'd1:    ch = 8'h30 + {3'b000, tens};
      4'd2:    ch = 8'h30 + {3'b000, ones};
      4'd3:    ch = 8'h3A;
      4'd4:    ch = 8'h20;
      default: ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endcase
    addr_full = (BASE_ROW + 32'(idx)) * COLS + BASE_COL + 32'(c);
  end

  // Outputs decode from registered state, so they stay frozen across stalls.
  always_comb begin
    wr.WR_EN   = (state == EMIT);
    wr.WR_ADDR = (state == EMIT) ? addr_full[ADDR_W-1:0] : '0;
    wr.WR_DATA = (state == EMIT) ? ch : 8'h00;
    RA         = idx;
    BUSY       = busy_q;
    DONE       = (state == FINISH);
  end

endmodule

// File: tb/tb_reg_hex_formatter.sv
// Randomized scoreboard bench for reg_hex_formatter.
module tb_reg_hex_formatter;
  localparam int COLS = 80, BASE_ROW = 0, BASE_COL = 0, ADDR_W = 12;

  logic        CLK = 1'b0, RST_RF = 1'b0, START = 1'b0;
  logic [4:0]  RA;
  logic [31:0] RDATA;
  logic        BUSY, DONE;
  logic [31:0] mem [32];

  reg_hex_formatter_if #(.ADDR_W(ADDR_W)) wr ();

  reg_hex_formatter #(.COLS(COLS), .BASE_ROW(BASE_ROW), .BASE_COL(BASE_COL), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_RF(RST_RF), .START(START), .RA(RA), .RDATA(RDATA),
    .wr(wr), .BUSY(BUSY), .DONE(DONE)
  );

  assign RDATA = mem[RA];
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: each register's line is built as text, then queued as address/char pairs.
  logic [ADDR_W+7:0] exp_q [$];
  task automatic push_expected();
    string hs;
    logic [7:0] ln [13];
    int addr;
    hs = "0123456789ABCDEF";
    for (int i = 0; i < 32; i++) begin
      ln[0] = "x";
      ln[1] = 8'(48 + i / 10);
      ln[2] = 8'(48 + i % 10);
      ln[3] = ":";
      ln[4] = " ";
      for (int n = 0; n < 8; n++) ln[5+n] = hs[int'((mem[i] >> (28 - 4 * n)) & 32'hF)];
      for (int k = 0; k < 13; k++) begin
        addr = ((BASE_ROW + i) * COLS + BASE_COL + k) % (1 << ADDR_W);
        exp_q.push_back({addr[ADDR_W-1:0], ln[k]});
      end
    end
  endtask

  // Ready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  int rdy_mode = 0;
  initial begin
    int ph;
    ph = 0;
    wr.WR_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        1: begin wr.WR_READY = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2: wr.WR_READY = 1'($urandom_range(0, 1));
        default: wr.WR_READY = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  int wr_cnt = 0, en_cnt = 0, stall_cnt = 0, done_cnt = 0;
  initial begin
    logic ps;
    logic [ADDR_W-1:0] pa;
    logic [7:0] pd;
    logic [ADDR_W+7:0] e;
    ps = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge CLK);
      if (ps) chk("stall_hold", {wr.WR_EN, wr.WR_ADDR, wr.WR_DATA}, {1'b1, pa, pd});
      if (DONE) begin
        done_cnt++;
        chk("done_busy_low", BUSY, 1'b0);
      end
      if (wr.WR_EN) en_cnt++;
      if (wr.WR_EN && wr.WR_READY && !RST_RF) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: addr=%0d data=%02h with empty queue", wr.WR_ADDR, wr.WR_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("write", {wr.WR_ADDR, wr.WR_DATA}, e);
        end
      end
      ps = wr.WR_EN && !wr.WR_READY;
      if (ps) stall_cnt++;
      pa = wr.WR_ADDR;
      pd = wr.WR_DATA;
    end
  end

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // One full refresh; optionally perturbs RDATA/START mid-pass or pokes START in FINISH.
  task automatic run_pass(input bit perturb, input bit start_in_finish);
    int w0, s0, d0, c0;
    bit got;
    push_expected();
    w0 = wr_cnt; s0 = stall_cnt; d0 = done_cnt;
    pulse_start();
    c0 = cyc;  // cycle T+k sees cyc == c0 + k - 1
    @(negedge CLK);
    chk("busy_after_start", {BUSY, RA, wr.WR_EN}, {1'b1, 5'd0, 1'b0});
    if (perturb) begin
      got = 0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge CLK);
        if (RA == 5'd3 && wr.WR_EN) begin got = 1; break; end
      end
      if (!got) begin n_chk++; $display("FAIL reach_idx3: timeout waiting for register 3 EMIT"); end
      mem[3] = ~mem[3];
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge CLK);
      if (DONE) begin got = 1; break; end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL done_timeout: no DONE within bound");
    end else begin
      chk("done_cycle", 64'(cyc - c0 + 1), 64'(449 + (stall_cnt - s0)));
      if (start_in_finish) begin
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        chk("start_in_finish_ignored", {BUSY, wr.WR_EN, DONE}, 3'b000);
      end
    end
    repeat (2) @(negedge CLK);
    chk("write_count", 64'(wr_cnt - w0), 64'd416);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int e0;
    bit got;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);

    RST_RF = 1'b1;
    #2;
    chk("reset_outputs", {RA, wr.WR_EN, wr.WR_ADDR, wr.WR_DATA, BUSY, DONE}, '0);
    @(negedge CLK);
    RST_RF = 1'b0;
    e0 = en_cnt;
    repeat (100) @(negedge CLK);
    chk("idle_no_wr_en", 64'(en_cnt - e0), 64'd0);
    chk("idle_busy", {BUSY, DONE}, 2'b00);

    // RDATA = idx, always ready
    rdy_mode = 0;
    run_pass(0, 0);

    // hex mapping patterns, START in FINISH cycle
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[7] = 32'hDEADBEEF;
    mem[8] = 32'h01234567;
    run_pass(0, 1);

    // 1,0,0,1 backpressure with snapshot disturbance and mid-pass START
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rdy_mode = 1;
    run_pass(1, 0);

    // random backpressure
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rdy_mode = 2;
    run_pass(0, 0);

    // reset at register 5, char 6
    rdy_mode = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    push_expected();
    pulse_start();
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (wr.WR_EN && wr.WR_ADDR == ADDR_W'((BASE_ROW + 5) * COLS + BASE_COL + 6)) begin got = 1; break; end
    end
    if (!got) begin n_chk++; $display("FAIL reach_reset_point: timeout"); end
    RST_RF = 1'b1;
    #1;
    chk("reset_midpass_outputs", {RA, wr.WR_EN, wr.WR_ADDR, wr.WR_DATA, BUSY, DONE}, '0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST_RF = 1'b0;
    e0 = en_cnt;
    repeat (20) @(negedge CLK);
    chk("post_reset_no_wr_en", 64'(en_cnt - e0), 64'd0);
    chk("post_reset_busy", BUSY, 1'b0);
    run_pass(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
